// File: rtl/ps2_pkg.sv
// Shared PS/2 constants and the command sequencer state type.
package ps2_pkg;

    // Keyboard protocol bytes
    localparam logic [7:0] PS2_ACK          = 8'hFA;
    localparam logic [7:0] PS2_RESEND       = 8'hFE;
    localparam logic [7:0] PS2_BREAK        = 8'hF0;
    localparam logic [7:0] PS2_EXT          = 8'hE0;
    localparam logic [7:0] PS2_CMD_SET_LED  = 8'hED;

    // Make codes of the lock keys whose LEDs the host keeps in sync
    localparam logic [7:0] PS2_SC_CAPS      = 8'h58;
    localparam logic [7:0] PS2_SC_NUM       = 8'h77;
    localparam logic [7:0] PS2_SC_SCROLL    = 8'h7E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_CMD,
        ST_WAIT_CMD,
        ST_SEND_ARG,
        ST_WAIT_ARG
    } state_t;

endpackage

// File: rtl/ps2_cmd_timer.sv
// Response timeout timer: loadable down-counter that stops at zero.
// expire is high in the cycle whose decrement brings the count to zero,
// so a registered consumer flags the timeout exactly when the count reads 0.
module ps2_cmd_timer #(
    parameter int TIMEOUT_CYC = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYC + 1);

    logic [W-1:0] count;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= W'(TIMEOUT_CYC);
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count <= W'(1));

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// Host-to-keyboard command sequencer.
// Sends one- or two-byte commands, waits for ACK after each byte, resends
// on RESEND up to MAX_RETRY times, and times out if the keyboard is silent.
// Bytes not consumed as responses are forwarded to the scan-code decoder.
// Optional feature macro: PS2_CMD_LED_TRACK_EN (lock-key LED tracking with
// self-issued set-LED commands).
//
// state       | meaning
// ------------+-------------------------------------------------
// ST_IDLE     | ready for a command, all rx bytes forwarded
// ST_SEND_CMD | command byte handed to transmitter, await tx_done
// ST_WAIT_CMD | awaiting ACK/RESEND for command byte, timer running
// ST_SEND_ARG | argument byte handed to transmitter, await tx_done
// ST_WAIT_ARG | awaiting ACK/RESEND for argument byte, timer running
module ps2_cmd_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 2500000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_req,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_has_arg,
    input  logic [7:0] cmd_arg,
    output logic       cmd_ready,
    output logic       cmd_done,
    output logic       cmd_err,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       scan_valid,
    output logic [7:0] scan_data
);

    localparam int RW = $clog2(MAX_RETRY + 1);

    state_t        state;
    logic [RW-1:0] retry;
    logic [7:0]    lat_cmd;
    logic [7:0]    lat_arg;
    logic          lat_has_arg;

    logic tmr_load, tmr_expire;
    logic in_wait, rx_ack, rx_resend, consumed, fwd;
    logic retry_ok, go_arg, resend_ok, fin_done, fin_err;
    logic led_issue;
    logic [7:0] led_arg;

    assign in_wait   = (state == ST_WAIT_CMD) || (state == ST_WAIT_ARG);
    assign rx_ack    = rx_valid && (rx_data == PS2_ACK);
    assign rx_resend = rx_valid && (rx_data == PS2_RESEND);
    assign consumed  = in_wait && (rx_ack || rx_resend);
    assign fwd       = rx_valid && !consumed;
    assign retry_ok  = retry < RW'(MAX_RETRY);

    assign go_arg    = (state == ST_WAIT_CMD) && rx_ack && lat_has_arg;
    assign resend_ok = in_wait && rx_resend && retry_ok;
    assign fin_done  = in_wait && rx_ack && !go_arg;
    // Any received byte takes precedence over a simultaneous timeout.
    assign fin_err   = in_wait && ((rx_resend && !retry_ok) || (!rx_valid && tmr_expire));

    assign tmr_load  = ((state == ST_SEND_CMD) || (state == ST_SEND_ARG)) && tx_done;

    ps2_cmd_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .expire (tmr_expire)
    );

    // Command sequencing FSM with registered handshake, tx and forwarding outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            retry       <= '0;
            lat_cmd     <= 8'h00;
            lat_arg     <= 8'h00;
            lat_has_arg <= 1'b0;
            cmd_ready   <= 1'b1;
            cmd_done    <= 1'b0;
            cmd_err     <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            scan_valid  <= 1'b0;
            scan_data   <= 8'h00;
        end else begin
            cmd_done   <= 1'b0;
            cmd_err    <= 1'b0;
            tx_start   <= 1'b0;
            scan_valid <= fwd;
            if (fwd) begin
                scan_data <= rx_data;
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_req) begin
                        lat_cmd     <= cmd_byte;
                        lat_arg     <= cmd_arg;
                        lat_has_arg <= cmd_has_arg;
                        retry       <= '0;
                        tx_start    <= 1'b1;
                        tx_data     <= cmd_byte;
                        cmd_ready   <= 1'b0;
                        state       <= ST_SEND_CMD;
                    end else if (led_issue) begin
                        lat_cmd     <= PS2_CMD_SET_LED;
                        lat_arg     <= led_arg;
                        lat_has_arg <= 1'b1;
                        retry       <= '0;
                        tx_start    <= 1'b1;
                        tx_data     <= PS2_CMD_SET_LED;
                        cmd_ready   <= 1'b0;
                        state       <= ST_SEND_CMD;
                    end
                end

                ST_SEND_CMD: begin
                    if (tx_done) begin
                        state <= ST_WAIT_CMD;
                    end
                end

                ST_SEND_ARG: begin
                    if (tx_done) begin
                        state <= ST_WAIT_ARG;
                    end
                end

                ST_WAIT_CMD, ST_WAIT_ARG: begin
                    if (go_arg) begin
                        retry    <= '0;
                        tx_start <= 1'b1;
                        tx_data  <= lat_arg;
                        state    <= ST_SEND_ARG;
                    end else if (resend_ok) begin
                        retry    <= retry + RW'(1);
                        tx_start <= 1'b1;
                        if (state == ST_WAIT_CMD) begin
                            tx_data <= lat_cmd;
                            state   <= ST_SEND_CMD;
                        end else begin
                            tx_data <= lat_arg;
                            state   <= ST_SEND_ARG;
                        end
                    end else if (fin_done) begin
                        cmd_done  <= 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (fin_err) begin
                        cmd_err   <= 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PS2_CMD_LED_TRACK_EN
    logic [2:0] led_state;
    logic [2:0] led_hit;
    logic       led_toggle;
    logic       led_pending;
    logic       led_active;
    logic       led_retoggle;
    logic       brk_prev;

    // Decode a forwarded lock-key make code into its LED bit {caps, num, scroll}.
    always_comb begin
        led_hit = 3'b000;
        if (fwd && !brk_prev) begin
            led_hit[2] = (rx_data == PS2_SC_CAPS);
            led_hit[1] = (rx_data == PS2_SC_NUM);
            led_hit[0] = (rx_data == PS2_SC_SCROLL);
        end
    end

    assign led_toggle = |led_hit;
    assign led_issue  = (state == ST_IDLE) && !cmd_req && led_pending;
    assign led_arg    = {5'b00000, led_state};

    // LED shadow state and pending-update flag; a toggle that lands while a
    // set-LED command is in flight keeps the flag set so the new mask is sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_state    <= 3'b000;
            led_pending  <= 1'b0;
            led_active   <= 1'b0;
            led_retoggle <= 1'b0;
            brk_prev     <= 1'b0;
        end else begin
            if (fwd) begin
                brk_prev <= (rx_data == PS2_BREAK);
            end
            if (led_toggle) begin
                led_state <= led_state ^ led_hit;
            end
            if (led_issue) begin
                led_active <= 1'b1;
            end
            if (led_active && (fin_done || fin_err)) begin
                led_active   <= 1'b0;
                led_pending  <= led_retoggle || led_toggle;
                led_retoggle <= 1'b0;
            end else if (led_toggle) begin
                led_pending <= 1'b1;
                if (led_active || led_issue) begin
                    led_retoggle <= 1'b1;
                end
            end
        end
    end
`else
    assign led_issue = 1'b0;
    assign led_arg   = 8'h00;
`endif

endmodule
